// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, read
// selects, FSM state type and default busy-cycle counts.
package mdu_seq_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;

    localparam logic MDU_RD_HI = 1'b0;
    localparam logic MDU_RD_LO = 1'b1;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;
    localparam int MDU_CNT_W_DEF       = 4;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator for mult/multu/div/divu.
// Produces {hi,lo} and flags a zero divisor so the caller can skip the write.
module mdu_calc
    import mdu_seq_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero
);

    logic [63:0] w_prod;

    // Select the arithmetic result for the requested op
    always_comb begin
        w_prod     = 64'd0;
        o_hi       = 32'd0;
        o_lo       = 32'd0;
        o_div_zero = 1'b0;
        case (i_op)
            MDU_MULT: begin
                w_prod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
                o_hi   = w_prod[63:32];
                o_lo   = w_prod[31:0];
            end
            MDU_MULTU: begin
                w_prod = {32'd0, i_a} * {32'd0, i_b};
                o_hi   = w_prod[63:32];
                o_lo   = w_prod[31:0];
            end
            MDU_DIV: begin
                if (i_b == 32'd0) begin
                    o_div_zero = 1'b1;
                end else if ((i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF)) begin
                    // Most-negative / -1 overflows; wrap the quotient, no remainder
                    o_lo = 32'h8000_0000;
                    o_hi = 32'd0;
                end else begin
                    o_lo = $signed(i_a) / $signed(i_b);
                    o_hi = $signed(i_a) % $signed(i_b);
                end
            end
            MDU_DIVU: begin
                if (i_b == 32'd0) begin
                    o_div_zero = 1'b1;
                end else begin
                    o_lo = i_a / i_b;
                    o_hi = i_a % i_b;
                end
            end
            default: begin
                o_div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit. The result is computed on the start
// edge and parked in pending registers; HI/LO only change when the busy
// countdown expires, which models the iterative latency seen by the pipeline.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
    parameter int CNT_W       = MDU_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] md_A,
    input  logic [31:0] md_B,
    input  logic        md_rd_sel,
    output logic [31:0] md_out,
    output logic        md_busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;
    logic [31:0]      r_pend_hi, w_pend_hi_nxt;
    logic [31:0]      r_pend_lo, w_pend_lo_nxt;
    logic             r_pend_wr, w_pend_wr_nxt;
    logic             r_busy, w_busy_nxt;

    logic [31:0]      w_calc_hi;
    logic [31:0]      w_calc_lo;
    logic             w_div_zero;

    mdu_calc u_calc (
        .i_op       (md_op),
        .i_a        (md_A),
        .i_b        (md_B),
        .o_hi       (w_calc_hi),
        .o_lo       (w_calc_lo),
        .o_div_zero (w_div_zero)
    );

    // State, counter, pending result and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= MDU_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic: accept ops in IDLE, count down and commit in BUSY
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;
        w_busy_nxt    = r_busy;
        case (r_state)
            MDU_IDLE: begin
                if (md_start) begin
                    case (md_op)
                        MDU_MULT, MDU_MULTU: begin
                            w_pend_hi_nxt = w_calc_hi;
                            w_pend_lo_nxt = w_calc_lo;
                            w_pend_wr_nxt = 1'b1;
                            w_cnt_nxt     = CNT_W'(MULT_CYCLES);
                            w_state_nxt   = MDU_BUSY;
                            w_busy_nxt    = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_pend_hi_nxt = w_calc_hi;
                            w_pend_lo_nxt = w_calc_lo;
                            // A zero divisor still runs the full latency but leaves HI/LO alone
                            w_pend_wr_nxt = ~w_div_zero;
                            w_cnt_nxt     = CNT_W'(DIV_CYCLES);
                            w_state_nxt   = MDU_BUSY;
                            w_busy_nxt    = 1'b1;
                        end
                        MDU_MTHI: begin
                            w_hi_nxt = md_A;
                        end
                        MDU_MTLO: begin
                            w_lo_nxt = md_A;
                        end
                        default: begin
                            w_state_nxt = MDU_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                // New requests are ignored here; the hazard unit never issues them
                if (r_cnt <= CNT_W'(1)) begin
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end else begin
                        w_hi_nxt = r_hi;
                    end
                    w_pend_wr_nxt = 1'b0;
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_state_nxt   = MDU_IDLE;
                    w_busy_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = MDU_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign md_busy = r_busy;
    assign HI      = r_hi;
    assign LO      = r_lo;
    // Reads see only committed values, never the pending result
    assign md_out  = md_rd_sel ? r_lo : r_hi;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected {HI,LO,busy length}
// per arithmetic op; a negedge monitor pops and checks on each busy fall.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        md_start = 1'b0;
    logic [3:0]  md_op = MDU_NONE;
    logic [31:0] md_A = 32'd0;
    logic [31:0] md_B = 32'd0;
    logic        md_rd_sel = 1'b0;
    logic [31:0] md_out;
    logic        md_busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          ncyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   proto_cnt = 0;

    mdu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_A      (md_A),
        .md_B      (md_B),
        .md_rd_sel (md_rd_sel),
        .md_out    (md_out),
        .md_busy   (md_busy),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int n);
        exp_t e;
        e.hi = hi; e.lo = lo; e.ncyc = n;
        q.push_back(e);
    endtask

    // One-cycle start strobe; returns 1 time unit after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        md_start = 1'b1; md_op = op; md_A = a; md_B = b;
        @(posedge clk); #1;
        md_start = 1'b0; md_op = MDU_NONE;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((md_busy || q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_idle: timed out busy=%0b pending=%0d required idle", md_busy, q.size());
        end
    endtask

    // Monitor: count busy cycles and compare the committed HI/LO at each busy fall
    initial begin
        int  cnt = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt  = 0;
                prev = 1'b0;
            end else begin
                if (md_busy) cnt++;
                if (md_start && md_busy) begin
                    proto_cnt++;
                    $display("note: protocol violation, md_start while busy at %0t", $time);
                end
                if (prev && !md_busy) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_unexpected: busy fell with no expected entry HI=%h LO=%h", HI, LO);
                    end else begin
                        e = q.pop_front();
                        chk("sb_busy_cycles", 32'(cnt), 32'(e.ncyc));
                        chk("sb_hi", HI, e.hi);
                        chk("sb_lo", LO, e.lo);
                    end
                    cnt = 0;
                end
                prev = md_busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle state
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        md_rd_sel = MDU_RD_HI; #1;
        chk("rst_out_hi", md_out, 32'd0);
        md_rd_sel = MDU_RD_LO; #1;
        chk("rst_out_lo", md_out, 32'd0);

        // MULT -2 * 3 = -6; HI/LO stay put while busy
        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk); @(negedge clk);
        chk("mult_busy_mid", 32'(md_busy), 32'd1);
        chk("mult_hi_hold", HI, 32'd0);
        chk("mult_lo_hold", LO, 32'd0);
        wait_idle();
        md_rd_sel = MDU_RD_LO; #1;
        chk("mult_out_lo", md_out, 32'hFFFF_FFFA);

        // DIVU 7/2 and DIV -7/2
        push(32'd1, 32'd3, 10);
        issue(MDU_DIVU, 32'd7, 32'd2);
        wait_idle();
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();

        // MTHI / MTLO are single-cycle and never raise busy
        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_busy", 32'(md_busy), 32'd0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_lo_keep", LO, 32'hFFFF_FFFD);
        issue(MDU_MTLO, 32'h0000_0009, 32'd0);
        chk("mtlo_busy", 32'(md_busy), 32'd0);
        chk("mtlo_lo", LO, 32'h0000_0009);
        md_rd_sel = MDU_RD_HI; #1;
        chk("sel_hi", md_out, 32'h1234_5678);
        md_rd_sel = MDU_RD_LO; #1;
        chk("sel_lo", md_out, 32'h0000_0009);

        // MULTU issued mid-DIV is ignored; DIV lands at its own deadline
        push(32'd2, 32'd14, 10);
        issue(MDU_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        md_start = 1'b1; md_op = MDU_MULTU; md_A = 32'd3; md_B = 32'd3;
        @(posedge clk); #1;
        md_start = 1'b0; md_op = MDU_NONE;
        wait_idle();
        chk("proto_seen", 32'(proto_cnt), 32'd1);

        // Divide by zero keeps previous HI/LO
        push(32'd2, 32'd14, 10);
        issue(MDU_DIV, 32'd5, 32'd0);
        wait_idle();

        // Signed overflow case
        push(32'd0, 32'h8000_0000, 10);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // NONE and undefined ops do nothing
        issue(MDU_NONE, 32'hDEAD_BEEF, 32'd1);
        chk("none_busy", 32'(md_busy), 32'd0);
        issue(4'hF, 32'hDEAD_BEEF, 32'd1);
        chk("undef_busy", 32'(md_busy), 32'd0);
        chk("undef_hi", HI, 32'd0);
        chk("undef_lo", LO, 32'h8000_0000);

        // Reset in busy cycle 3 of a MULT discards the pending result
        issue(MDU_MULT, 32'd7, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(md_busy), 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        @(posedge clk); #2 reset = 1'b1;

        push(32'd0, 32'd20, 5);
        issue(MDU_MULT, 32'd4, 32'd5);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
